// File: rtl/router_pkt_src.sv
// router_pkt_src: transmitting end of the router input-port protocol.
// A request latches destination and length, the whole payload is buffered
// from the upstream byte stream, then header, payload and XOR parity are
// presented to the router, each byte held for as long as busy is high.
module router_pkt_src #(
  parameter int LEN_WIDTH = 6,
  parameter int IPG       = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [1:0]           dest,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 start_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 busy,
  input  logic                 err,
  output logic                 pkt_valid,
  output logic [7:0]           data_out,
  output logic                 done,
  output logic                 req_err,
  output logic                 err_seen,
  output logic                 tx_active
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  // One spare entry lets any pointer value index the array directly;
  // pointers never exceed len-1 so the last entry is never used.
  localparam int DEPTH = 2 ** LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]           state;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] wptr;
  logic [LEN_WIDTH-1:0] rptr;
  logic [7:0]           header;
  logic [7:0]           parity;
  logic [3:0]           gap_cnt;
  logic                 after_gap;
  logic [7:0]           buffer [DEPTH];

  logic [7:0]           header_next;
  logic                 bad_req;

  // Request decode: header packs the length above the 2-bit destination.
  always_comb begin
    header_next = 8'({len, dest});
    bad_req     = (dest == 2'd3) || (len == '0);
  end

  // Control state, pointers, running parity and the status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      len_r     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      header    <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      after_gap <= 1'b0;
      done      <= 1'b0;
      req_err   <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      done      <= 1'b0;
      req_err   <= 1'b0;
      after_gap <= 1'b0;
      if (err && ((state == S_PARITY) || (state == S_GAP) || after_gap)) begin
        err_seen <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start && start_ready) begin
            if (bad_req) begin
              req_err <= 1'b1;
            end else begin
              state    <= S_LOAD;
              len_r    <= len;
              header   <= header_next;
              parity   <= header_next;
              wptr     <= '0;
              rptr     <= '0;
              err_seen <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            parity <= parity ^ s_data;
            wptr   <= wptr + LEN_ONE;
            if (wptr == len_r - LEN_ONE) begin
              state <= S_HEADER;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            rptr <= rptr + LEN_ONE;
            if (rptr == len_r - LEN_ONE) begin
              state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            state   <= S_GAP;
            gap_cnt <= 4'(IPG - 1);
            done    <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) begin
            state     <= S_IDLE;
            after_gap <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload storage; contents need no reset because reads follow writes.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && s_valid) begin
      buffer[wptr] <= s_data;
    end
  end

  // Outputs decode from state only, so busy never reaches them combinationally.
  always_comb begin
    start_ready = (state == S_IDLE) && (gap_cnt == 4'd0);
    s_ready     = (state == S_LOAD);
    tx_active   = (state != S_IDLE);
    pkt_valid   = 1'b0;
    data_out    = 8'h00;
    case (state)
      S_HEADER: begin
        pkt_valid = 1'b1;
        data_out  = header;
      end
      S_PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = buffer[rptr];
      end
      S_PARITY: begin
        data_out  = parity;
      end
      default: begin
        pkt_valid = 1'b0;
        data_out  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: randomized checks of router_pkt_src against a
// packet-level reference model (header, payload, XOR parity stream).
module tb_router_pkt_src;

  localparam int LW     = 6;
  localparam int IPG    = 2;
  localparam int BUDGET = 600;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [1:0]    dest;
  logic [LW-1:0] len;
  logic          start_ready;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          busy;
  logic          err;
  logic          pkt_valid;
  logic [7:0]    data_out;
  logic          done;
  logic          req_err;
  logic          err_seen;
  logic          tx_active;

  int vectors     = 0;
  int miscompares = 0;

  router_pkt_src #(.LEN_WIDTH(LW), .IPG(IPG)) dut (
    .clk(clk), .resetn(resetn), .start(start), .dest(dest), .len(len),
    .start_ready(start_ready), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .busy(busy), .err(err), .pkt_valid(pkt_valid),
    .data_out(data_out), .done(done), .req_err(req_err),
    .err_seen(err_seen), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: what the router must receive for one packet.
  function automatic bq_t expected_stream(input int d, input int n, input bq_t pl);
    bq_t e;
    logic [7:0] hdr;
    logic [7:0] par;
    hdr = 8'((n << 2) | d);
    par = hdr;
    e.push_back(hdr);
    foreach (pl[i]) begin
      e.push_back(pl[i]);
      par = par ^ pl[i];
    end
    e.push_back(par);
    return e;
  endfunction

  function automatic bq_t random_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Drives one request, feeds the payload and plays the router; records
  // every consumed byte. sval_pct < 0 toggles s_valid every cycle.
  task automatic send_packet(
    input int d, input int n, input bq_t pl,
    input int busy_pct, input int sval_pct,
    input int hold_at, input int hold_cycles, input int abort_at, input bit err_noise,
    output bq_t obs, output bq_t held_data, output int held_pv,
    output int par_cycle, output int gap_len, output int done_cnt,
    output bit done_first, output bit early, output bit timed_out);
    int  widx;
    int  hold_left;
    bit  hold_on;
    bit  got_par;
    bit  finished;
    obs.delete();
    held_data.delete();
    held_pv = 0; par_cycle = 0; gap_len = 0; done_cnt = 0;
    done_first = 1'b0; early = 1'b0; timed_out = 1'b0;
    widx = 0; hold_left = hold_cycles; hold_on = 1'b0; got_par = 1'b0; finished = 1'b0;
    @(negedge clk);
    start = 1'b1; dest = 2'(d); len = LW'(n);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (got_par && !tx_active) begin
        finished = 1'b1;
        break;
      end
      if (done) begin
        done_cnt++;
        if (k == par_cycle + 1) done_first = 1'b1;
      end
      if (got_par) gap_len++;
      if (abort_at > 0 && pkt_valid && obs.size() == abort_at) return;
      if (pkt_valid && widx < n) early = 1'b1;
      s_valid = (sval_pct < 0) ? k[0] : ($urandom_range(99) < sval_pct);
      s_data  = (widx < n) ? pl[widx] : 8'hEE;
      if (s_ready && s_valid && widx < n) widx++;
      err = 1'b0;
      if (hold_left > 0 && (hold_on || (pkt_valid && obs.size() == hold_at))) begin
        hold_on = 1'b1;
        hold_left--;
        busy = 1'b1;
        held_data.push_back(data_out);
        if (pkt_valid) held_pv++;
      end else begin
        busy = ($urandom_range(99) < busy_pct);
      end
      if (err_noise && (pkt_valid || s_ready)) err = 1'($urandom_range(1));
      if (pkt_valid && !busy) begin
        obs.push_back(data_out);
      end else if (!pkt_valid && tx_active && !s_ready && !got_par && obs.size() == n + 1 && !busy) begin
        obs.push_back(data_out);
        got_par = 1'b1;
        par_cycle = k;
      end
      @(negedge clk);
    end
    if (!finished) timed_out = 1'b1;
    s_valid = 1'b0; busy = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({pkt_valid, s_ready, done, req_err, err_seen, tx_active, start_ready, data_out} !== {7'b0000001, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %b/%h expected 0000001/00",
               {pkt_valid, s_ready, done, req_err, err_seen, tx_active, start_ready}, data_out);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pkt_valid, s_ready, done, req_err, err_seen, tx_active, start_ready, data_out} !== {7'b0000001, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got %b/%h expected 0000001/00",
               {pkt_valid, s_ready, done, req_err, err_seen, tx_active, start_ready}, data_out);
    end
  endtask

  task automatic test_basic();
    bq_t pl, obs, held, e;
    int  hpv, pc, gl, dc;
    bit  df, ea, to;
    for (int i = 1; i <= 12; i++) pl.push_back(8'(i));
    e = expected_stream(1, 12, pl);
    send_packet(1, 12, pl, 0, 100, -1, 0, 0, 1'b0, obs, held, hpv, pc, gl, dc, df, ea, to);
    vectors++;
    if (to || obs.size() != e.size()) begin
      miscompares++;
      $display("[TB] FAIL basic_len: got %0d bytes (timeout %0d) expected %0d", obs.size(), to, e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        vectors++;
        if (obs[i] !== e[i]) begin
          miscompares++;
          $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, obs[i], e[i]);
        end
      end
      vectors++;
      if (obs[0] !== 8'h31 || obs[13] !== 8'h3D) begin
        miscompares++;
        $display("[TB] FAIL basic_hdr_par: got %h/%h expected 31/3d", obs[0], obs[13]);
      end
    end
    vectors++;
    if (dc != 1 || !df) begin
      miscompares++;
      $display("[TB] FAIL basic_done: got %0d pulses first=%0d expected 1 first=1", dc, df);
    end
    vectors++;
    if (pc != 2 * 12 + 2) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", pc, 2 * 12 + 2);
    end
    vectors++;
    if (gl != IPG) begin
      miscompares++;
      $display("[TB] FAIL basic_gap: got %0d expected %0d", gl, IPG);
    end
  endtask

  task automatic test_busy_hold();
    bq_t pl, obs, held, e;
    int  hpv, pc, gl, dc;
    bit  df, ea, to;
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'h10 + i));
    e = expected_stream(2, 16, pl);
    send_packet(2, 16, pl, 0, 100, 5, 3, 0, 1'b0, obs, held, hpv, pc, gl, dc, df, ea, to);
    vectors++;
    if (held.size() != 3 || hpv != 3) begin
      miscompares++;
      $display("[TB] FAIL hold_count: got %0d cycles %0d valid expected 3 3", held.size(), hpv);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (held[i] !== 8'h14) begin
          miscompares++;
          $display("[TB] FAIL hold_byte%0d: got %h expected 14", i, held[i]);
        end
      end
    end
    vectors++;
    if (to || obs.size() != e.size()) begin
      miscompares++;
      $display("[TB] FAIL hold_len: got %0d bytes (timeout %0d) expected %0d", obs.size(), to, e.size());
    end else begin
      vectors++;
      if (obs[0] !== 8'h42) begin
        miscompares++;
        $display("[TB] FAIL hold_hdr: got %h expected 42", obs[0]);
      end
      for (int i = 0; i < e.size(); i++) begin
        vectors++;
        if (obs[i] !== e[i]) begin
          miscompares++;
          $display("[TB] FAIL hold_byte_out%0d: got %h expected %h", i, obs[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_svalid_gaps();
    bq_t pl, obs, held, e;
    int  hpv, pc, gl, dc;
    bit  df, ea, to;
    pl = random_payload(18);
    e = expected_stream(0, 18, pl);
    send_packet(0, 18, pl, 0, -1, -1, 0, 0, 1'b0, obs, held, hpv, pc, gl, dc, df, ea, to);
    vectors++;
    if (ea) begin
      miscompares++;
      $display("[TB] FAIL gaps_early: got pkt_valid before last write expected none");
    end
    vectors++;
    if (to || obs.size() != e.size()) begin
      miscompares++;
      $display("[TB] FAIL gaps_len: got %0d bytes (timeout %0d) expected %0d", obs.size(), to, e.size());
    end else begin
      vectors++;
      if (obs[0] !== 8'h48) begin
        miscompares++;
        $display("[TB] FAIL gaps_hdr: got %h expected 48", obs[0]);
      end
      for (int i = 0; i < e.size(); i++) begin
        vectors++;
        if (obs[i] !== e[i]) begin
          miscompares++;
          $display("[TB] FAIL gaps_byte%0d: got %h expected %h", i, obs[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_req_err();
    int pv_hits;
    pv_hits = 0;
    @(negedge clk);
    start = 1'b1; dest = 2'd1; len = '0;
    @(negedge clk);
    start = 1'b0;
    if (pkt_valid || tx_active) pv_hits++;
    vectors++;
    if (req_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL req_err_len0: got %b expected 1", req_err);
    end
    @(negedge clk);
    if (pkt_valid || tx_active) pv_hits++;
    vectors++;
    if (req_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL req_err_len0_pulse: got %b expected 0", req_err);
    end
    start = 1'b1; dest = 2'd3; len = LW'(5);
    @(negedge clk);
    start = 1'b0;
    if (pkt_valid || tx_active) pv_hits++;
    vectors++;
    if (req_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL req_err_dest3: got %b expected 1", req_err);
    end
    repeat (3) begin
      @(negedge clk);
      if (pkt_valid || tx_active) pv_hits++;
    end
    vectors++;
    if (pv_hits != 0 || req_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL req_err_idle: got %0d active cycles req_err=%b expected 0 0", pv_hits, req_err);
    end
  endtask

  task automatic test_reset_mid();
    bq_t pl, obs, held, e;
    int  hpv, pc, gl, dc;
    bit  df, ea, to;
    pl = random_payload(10);
    send_packet(1, 10, pl, 0, 100, -1, 0, 6, 1'b0, obs, held, hpv, pc, gl, dc, df, ea, to);
    vectors++;
    if (!pkt_valid || data_out !== pl[5]) begin
      miscompares++;
      $display("[TB] FAIL abort_point: got pv=%b %h expected pv=1 %h", pkt_valid, data_out, pl[5]);
    end
    #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({pkt_valid, tx_active, s_ready, done, data_out} !== {4'b0000, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %b/%h expected 0000/00", {pkt_valid, tx_active, s_ready, done}, data_out);
    end
    s_valid = 1'b0; busy = 1'b0; err = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    pl = random_payload(20);
    e = expected_stream(2, 20, pl);
    send_packet(2, 20, pl, 20, 80, -1, 0, 0, 1'b0, obs, held, hpv, pc, gl, dc, df, ea, to);
    vectors++;
    if (to || obs.size() != e.size()) begin
      miscompares++;
      $display("[TB] FAIL after_reset_len: got %0d bytes (timeout %0d) expected %0d", obs.size(), to, e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        vectors++;
        if (obs[i] !== e[i]) begin
          miscompares++;
          $display("[TB] FAIL after_reset_byte%0d: got %h expected %h", i, obs[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int         n;
    int         d;
    int         per;
    int         r;
    int         p;
    logic [7:0] hdr;
    logic [7:0] pay;
    logic [7:0] par;
    logic [7:0] exp_do;
    logic       exp_pv;
    logic       exp_done;
    logic       exp_es;
    logic       exp_sr;
    n = 1; d = 2;
    per = 2 * n + 3 + IPG;
    hdr = 8'((n << 2) | d);
    pay = 8'hA5;
    par = hdr ^ pay;
    @(negedge clk);
    s_data = pay; s_valid = 1'b1; busy = 1'b0; err = 1'b0;
    dest = 2'(d); len = LW'(n); start = 1'b1;
    for (int k = 1; k <= 3 * per; k++) begin
      @(negedge clk);
      r = (k - 1) % per + 1;
      p = (k - 1) / per;
      exp_pv   = (r >= n + 1) && (r <= 2 * n + 1);
      exp_do   = (r == n + 1) ? hdr : (exp_pv ? pay : ((r == 2 * n + 2) ? par : 8'h00));
      exp_done = (r == 2 * n + 3);
      exp_es   = (p == 0) && (r >= 2 * n + 3);
      exp_sr   = (r == per);
      vectors++;
      if ({pkt_valid, done, err_seen, start_ready, data_out} !== {exp_pv, exp_done, exp_es, exp_sr, exp_do}) begin
        miscompares++;
        $display("[TB] FAIL b2b_cycle%0d: got pv/done/es/rdy=%b data=%h expected %b data=%h", k,
                 {pkt_valid, done, err_seen, start_ready}, data_out, {exp_pv, exp_done, exp_es, exp_sr}, exp_do);
      end
      err = (p == 0) && (r == 2 * n + 2);
      if (k == 3 * per) start = 1'b0;
    end
    err = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_stop: got tx_active=%b expected 0", tx_active);
    end
  endtask

  task automatic test_random();
    bq_t pl, obs, held, e;
    int  hpv, pc, gl, dc;
    bit  df, ea, to;
    int  n;
    int  d;
    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? 63 : ((t == 1) ? 1 : int'($urandom_range(63, 1)));
      d = int'($urandom_range(2));
      pl = random_payload(n);
      e = expected_stream(d, n, pl);
      send_packet(d, n, pl, 30, 70, -1, 0, 0, 1'b1, obs, held, hpv, pc, gl, dc, df, ea, to);
      vectors++;
      if (to || obs.size() != e.size()) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_len: got %0d bytes (timeout %0d) expected %0d", t, obs.size(), to, e.size());
      end else begin
        for (int i = 0; i < e.size(); i++) begin
          vectors++;
          if (obs[i] !== e[i]) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", t, i, obs[i], e[i]);
          end
        end
      end
      vectors++;
      if (dc != 1 || gl != IPG || ea) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_ctrl: got done=%0d gap=%0d early=%0d expected 1 %0d 0", t, dc, gl, ea, IPG);
      end
      vectors++;
      if (err_seen !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_err_seen: got %b expected 0", t, err_seen);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    resetn = 1'b0; start = 1'b0; dest = 2'd0; len = '0;
    s_data = 8'h00; s_valid = 1'b0; busy = 1'b0; err = 1'b0;
    $display("[TB] starting router_pkt_src scenarios");
    test_reset();
    test_basic();
    test_busy_hold();
    test_svalid_gaps();
    test_req_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
